// File: rtl/man_demod_pkg.sv
// Shared definitions for the ISO14443A card-to-reader Manchester decoder:
// FSM state encodings, ETU timing constants and per-ETU symbol class codes.
package man_demod_pkg;

  localparam int ETU_CLKS   = 8;  // fc/16 clocks per ETU
  localparam int ETU_HALF   = 4;  // clocks per half-ETU
  localparam int ETU_THRESH = 2;  // high samples needed for a "modulated" half

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SOF_CHK = 2'd1,
    RX      = 2'd2
  } state_t;

  // Symbol carried by one ETU, from the (first half, second half) pattern.
  typedef enum logic [1:0] {
    BIT0 = 2'd0,  // not M / M
    BIT1 = 2'd1,  // M / not M
    EOF  = 2'd2,  // not M / not M
    COLL = 2'd3   // M / M
  } etu_class_t;

  function automatic etu_class_t classify(input logic m1, input logic m2);
    etu_class_t c;
    case ({m1, m2})
      2'b10:   c = BIT1;
      2'b01:   c = BIT0;
      2'b00:   c = EOF;
      default: c = COLL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/man_etu_sampler.sv
// ETU sampler: counts position within the ETU, accumulates high samples in
// each half, and on the 8th sample raises etu_done with the symbol class.
// start marks sample 0 of a new ETU (the SOF rising edge); run keeps the
// counter free-running back to back while a frame is being received.
module man_etu_sampler
  import man_demod_pkg::*;
#(
  parameter int N      = 3,
  parameter int HALF   = ETU_HALF,
  parameter int THRESH = ETU_THRESH
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic       run,
  input  logic       sample,
  output logic       etu_done,
  output logic [1:0] etu_class
);

  logic [N-1:0] cnt;
  logic [N-1:0] h1;
  logic [N-1:0] h2;
  logic [N-1:0] sample_w;
  logic [N-1:0] h2_total;
  logic         last;
  logic         second_half;

  assign sample_w    = {{(N-1){1'b0}}, sample};
  assign last        = (cnt == N'(2 * HALF - 1));
  assign second_half = (cnt >= N'(HALF));
  // The 8th sample belongs to the second half but is not yet in h2.
  assign h2_total    = h2 + sample_w;
  assign etu_done    = run && last;
  assign etu_class   = classify(h1 >= N'(THRESH), h2_total >= N'(THRESH));

  // Position counter and per-half high-sample accumulators.
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
      h1  <= '0;
      h2  <= '0;
    end else if (start) begin
      cnt <= N'(1);
      h1  <= sample_w;
      h2  <= '0;
    end else if (run) begin
      if (last) begin
        cnt <= '0;
        h1  <= '0;
        h2  <= '0;
      end else begin
        cnt <= cnt + N'(1);
        if (second_half) h2 <= h2 + sample_w;
        else             h1 <= h1 + sample_w;
      end
    end
  end

endmodule

// File: rtl/man_demod.sv
// Manchester decoder, card-to-reader direction of ISO14443A at 106 kb/s.
// Detects SOF, data bits, EOF and collisions; assembles bytes LSB-first and
// checks odd parity on full 9-bit characters.
// Output handshake: out_byte_valid and out_frame_done are one-cycle strobes
// with no back-pressure; out_byte/out_nbits/out_parity_err are qualified by
// out_byte_valid and hold until the next one; out_coll is a pulse aligned
// with out_byte_valid. dbg_state mirrors the FSM state register.
module man_demod
  import man_demod_pkg::*;
#(
  parameter int N      = 3,
  parameter int HALF   = ETU_HALF,
  parameter int THRESH = ETU_THRESH
) (
  input  logic       clk,
  input  logic       in_rst,
  input  logic       in_enable,
  input  logic       in_data,
  output logic [7:0] out_byte,
  output logic [3:0] out_nbits,
  output logic       out_byte_valid,
  output logic       out_parity_err,
  output logic       out_coll,
  output logic       out_frame_done,
  output logic       out_busy,
  output logic [1:0] dbg_state
);

  state_t     state, state_nxt;
  logic [3:0] bitcnt, bitcnt_nxt;
  logic [7:0] shreg, shreg_nxt;
  logic [7:0] byte_nxt;
  logic [3:0] nbits_nxt;
  logic       perr_nxt, valid_nxt, coll_nxt, done_nxt;
  logic       prev;
  logic       clr;
  logic       sof_start;
  logic       etu_done;
  logic [1:0] etu_class;
  logic       bit_val;

  assign clr       = in_rst | ~in_enable;
  assign out_busy  = (state != IDLE);
  assign dbg_state = state;
  assign bit_val   = (etu_class == BIT1);

  man_etu_sampler #(.N(N), .HALF(HALF), .THRESH(THRESH)) u_sampler (
    .clk       (clk),
    .clr       (clr),
    .start     (sof_start),
    .run       (state != IDLE),
    .sample    (in_data),
    .etu_done  (etu_done),
    .etu_class (etu_class)
  );

  // Next-state and output decode: acts only on the ETU boundary outside IDLE.
  always_comb begin
    state_nxt  = state;
    bitcnt_nxt = bitcnt;
    shreg_nxt  = shreg;
    byte_nxt   = out_byte;
    nbits_nxt  = out_nbits;
    perr_nxt   = out_parity_err;
    valid_nxt  = 1'b0;
    coll_nxt   = 1'b0;
    done_nxt   = 1'b0;
    sof_start  = 1'b0;
    case (state)
      IDLE: begin
        if (in_data && !prev) begin
          sof_start = 1'b1;
          state_nxt = SOF_CHK;
        end
      end
      SOF_CHK: begin
        if (etu_done) begin
          if (etu_class == BIT1) begin
            state_nxt  = RX;
            bitcnt_nxt = 4'd0;
            shreg_nxt  = 8'd0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      RX: begin
        if (etu_done) begin
          case (etu_class)
            BIT0, BIT1: begin
              if (bitcnt == 4'd8) begin
                // Parity bit closes a full character; stay for the next one.
                valid_nxt  = 1'b1;
                byte_nxt   = shreg;
                nbits_nxt  = 4'd8;
                perr_nxt   = ~(^{shreg, bit_val});
                bitcnt_nxt = 4'd0;
                shreg_nxt  = 8'd0;
              end else begin
                shreg_nxt[bitcnt[2:0]] = bit_val;
                bitcnt_nxt             = bitcnt + 4'd1;
              end
            end
            EOF: begin
              done_nxt  = 1'b1;
              state_nxt = IDLE;
              if (bitcnt != 4'd0) begin
                valid_nxt = 1'b1;
                byte_nxt  = shreg;
                nbits_nxt = bitcnt;
                perr_nxt  = 1'b0;
              end
            end
            default: begin
              valid_nxt = 1'b1;
              coll_nxt  = 1'b1;
              done_nxt  = 1'b1;
              byte_nxt  = shreg;
              nbits_nxt = bitcnt;
              perr_nxt  = 1'b0;
              state_nxt = IDLE;
            end
          endcase
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, datapath and registered outputs; reset and disable both clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      state          <= IDLE;
      bitcnt         <= 4'd0;
      shreg          <= 8'd0;
      prev           <= 1'b0;
      out_byte       <= 8'd0;
      out_nbits      <= 4'd0;
      out_parity_err <= 1'b0;
      out_byte_valid <= 1'b0;
      out_coll       <= 1'b0;
      out_frame_done <= 1'b0;
    end else begin
      state          <= state_nxt;
      bitcnt         <= bitcnt_nxt;
      shreg          <= shreg_nxt;
      prev           <= in_data;
      out_byte       <= byte_nxt;
      out_nbits      <= nbits_nxt;
      out_parity_err <= perr_nxt;
      out_byte_valid <= valid_nxt;
      out_coll       <= coll_nxt;
      out_frame_done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_man_demod.sv
// Testbench for man_demod. Each output event (a cycle with out_byte_valid or
// out_frame_done) is packed as {valid, done, coll, parity_err, nbits, byte}
// and compared in order against expectations pushed while driving frames.
module tb_man_demod;

  logic       clk = 1'b0;
  logic       in_rst;
  logic       in_enable;
  logic       in_data;
  logic [7:0] out_byte;
  logic [3:0] out_nbits;
  logic       out_byte_valid;
  logic       out_parity_err;
  logic       out_coll;
  logic       out_frame_done;
  logic       out_busy;
  logic [1:0] dbg_state;

  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  int vectors     = 0;
  int miscompares = 0;

  man_demod dut (
    .clk            (clk),
    .in_rst         (in_rst),
    .in_enable      (in_enable),
    .in_data        (in_data),
    .out_byte       (out_byte),
    .out_nbits      (out_nbits),
    .out_byte_valid (out_byte_valid),
    .out_parity_err (out_parity_err),
    .out_coll       (out_coll),
    .out_frame_done (out_frame_done),
    .out_busy       (out_busy),
    .dbg_state      (dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected summary");
    $fatal(1, "watchdog");
  end

  // Output event monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (out_byte_valid || out_frame_done)
      obs_q.push_back({out_byte_valid, out_frame_done, out_coll, out_parity_err,
                       out_nbits, out_byte});
  end

  function automatic logic [15:0] ev(input logic v, input logic d, input logic c,
                                     input logic p, input logic [3:0] n,
                                     input logic [7:0] b);
    return {v, d, c, p, n, b};
  endfunction

  // Parity bit that makes the 9-bit character have an odd number of ones
  function automatic logic odd_par_bit(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) if (b[i]) ones++;
    return (ones % 2 == 0);
  endfunction

  // Driver tasks: one sample per clock, applied on the falling edge
  task automatic drive(input logic v);
    @(negedge clk);
    in_data = v;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0);
  endtask

  task automatic send_etu(input logic a, input logic b, input logic flip);
    int fa;
    int fb;
    fa = $urandom_range(0, 3);
    fb = $urandom_range(0, 3);
    for (int i = 0; i < 4; i++) drive(a ^ (flip && i == fa));
    for (int i = 0; i < 4; i++) drive(b ^ (flip && i == fb));
  endtask

  task automatic send_sof();
    send_etu(1'b1, 1'b0, 1'b0);
  endtask

  task automatic send_bit(input logic b, input logic flip);
    if (b) send_etu(1'b1, 1'b0, flip);
    else   send_etu(1'b0, 1'b1, flip);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n, input logic flip);
    for (int i = 0; i < n; i++) send_bit(b[i], flip);
  endtask

  task automatic send_eof(input logic flip);
    send_etu(1'b0, 1'b0, flip);
  endtask

  // Scenario tasks
  task automatic test_reset();
    in_rst    = 1'b1;
    in_enable = 1'b1;
    in_data   = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({out_byte, out_nbits, out_byte_valid, out_parity_err, out_coll,
         out_frame_done, out_busy, dbg_state} !== 20'd0) begin
      miscompares++;
      $display("FAIL reset: outputs got byte=%h nbits=%0d v=%b p=%b c=%b d=%b busy=%b st=%0d, expected all 0",
               out_byte, out_nbits, out_byte_valid, out_parity_err, out_coll,
               out_frame_done, out_busy, dbg_state);
    end
    in_rst = 1'b0;
    idle(4);
    vectors++;
    if (obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL reset_idle: got %0d events, expected 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_short_frame();
    logic [15:0] e, o;
    // REQA: 7 bits, no parity
    send_sof();
    send_bits(8'h26, 7, 1'b0);
    send_eof(1'b0);
    exp_q.push_back(ev(1, 1, 0, 0, 4'd7, 8'h26));
    idle(3);
    // Eight bits then EOF: parity missing
    send_sof();
    send_bits(8'hC3, 8, 1'b0);
    send_eof(1'b0);
    exp_q.push_back(ev(1, 1, 0, 0, 4'd8, 8'hC3));
    idle(4);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++;
        $display("FAIL short_frame: got no event, expected %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          miscompares++;
          $display("FAIL short_frame: got event %h, expected %h", o, e);
        end
      end
    end
    vectors++;
    if (obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL short_frame: got %0d extra events, expected 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_parity();
    logic [15:0] e, o;
    logic        par;
    par = odd_par_bit(8'h93);
    send_sof();
    send_bits(8'h93, 8, 1'b0);
    send_bit(par, 1'b0);
    send_eof(1'b0);
    exp_q.push_back(ev(1, 0, 0, 0, 4'd8, 8'h93));
    exp_q.push_back(ev(0, 1, 0, 0, 4'd8, 8'h93));
    idle(3);
    send_sof();
    send_bits(8'h93, 8, 1'b0);
    send_bit(~par, 1'b0);
    send_eof(1'b0);
    exp_q.push_back(ev(1, 0, 0, 1, 4'd8, 8'h93));
    exp_q.push_back(ev(0, 1, 0, 1, 4'd8, 8'h93));
    idle(4);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++;
        $display("FAIL parity: got no event, expected %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          miscompares++;
          $display("FAIL parity: got event %h, expected %h", o, e);
        end
      end
    end
    vectors++;
    if (obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL parity: got %0d extra events, expected 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_collision();
    logic [15:0] e, o;
    send_sof();
    send_bits(8'h05, 3, 1'b0);
    send_etu(1'b1, 1'b1, 1'b0);
    exp_q.push_back(ev(1, 1, 1, 0, 4'd3, 8'h05));
    idle(4);
    vectors++;
    if (out_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL collision_idle: busy got %b, expected 0", out_busy);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++;
        $display("FAIL collision: got no event, expected %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          miscompares++;
          $display("FAIL collision: got event %h, expected %h", o, e);
        end
      end
    end
    vectors++;
    if (obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL collision: got %0d extra events, expected 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_glitch();
    drive(1'b1);
    for (int j = 1; j <= 8; j++) begin
      drive(1'b0);
      vectors++;
      if (out_busy !== (j <= 7)) begin
        miscompares++;
        $display("FAIL glitch_busy: clock %0d busy got %b, expected %b", j, out_busy, (j <= 7));
      end
    end
    idle(8);
    vectors++;
    if (obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL glitch: got %0d events, expected 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_rst_mid();
    logic [15:0] e, o;
    send_sof();
    send_bits(8'h0B, 4, 1'b0);
    @(negedge clk);
    in_rst  = 1'b1;
    in_data = 1'b0;
    @(negedge clk);
    vectors++;
    if ({out_byte, out_nbits, out_byte_valid, out_parity_err, out_coll,
         out_frame_done, out_busy, dbg_state} !== 20'd0) begin
      miscompares++;
      $display("FAIL rst_mid: outputs got byte=%h nbits=%0d busy=%b st=%0d, expected all 0",
               out_byte, out_nbits, out_busy, dbg_state);
    end
    in_rst = 1'b0;
    idle(4);
    send_sof();
    send_bits(8'hA5, 8, 1'b0);
    send_bit(odd_par_bit(8'hA5), 1'b0);
    send_eof(1'b0);
    exp_q.push_back(ev(1, 0, 0, 0, 4'd8, 8'hA5));
    exp_q.push_back(ev(0, 1, 0, 0, 4'd8, 8'hA5));
    idle(4);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++;
        $display("FAIL rst_mid: got no event, expected %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          miscompares++;
          $display("FAIL rst_mid: got event %h, expected %h", o, e);
        end
      end
    end
    vectors++;
    if (obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL rst_mid: got %0d extra events, expected 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_majority();
    logic [15:0] e, o;
    send_sof();
    send_bits(8'h93, 8, 1'b1);
    send_bit(odd_par_bit(8'h93), 1'b1);
    send_eof(1'b1);
    exp_q.push_back(ev(1, 0, 0, 0, 4'd8, 8'h93));
    exp_q.push_back(ev(0, 1, 0, 0, 4'd8, 8'h93));
    idle(4);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++;
        $display("FAIL majority: got no event, expected %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          miscompares++;
          $display("FAIL majority: got event %h, expected %h", o, e);
        end
      end
    end
    vectors++;
    if (obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL majority: got %0d extra events, expected 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_disable();
    send_sof();
    send_bits(8'h07, 3, 1'b0);
    @(negedge clk);
    in_enable = 1'b0;
    in_data   = 1'b0;
    @(negedge clk);
    vectors++;
    if ({out_byte, out_nbits, out_busy, dbg_state} !== 15'd0) begin
      miscompares++;
      $display("FAIL disable: got byte=%h nbits=%0d busy=%b st=%0d, expected all 0",
               out_byte, out_nbits, out_busy, dbg_state);
    end
    in_enable = 1'b1;
    idle(10);
    vectors++;
    if (obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL disable: got %0d events, expected 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] e, o;
    logic [7:0]  b;
    logic        p;
    logic        perr;
    int          nbytes;
    for (int f = 0; f < 3; f++) begin
      send_sof();
      nbytes = $urandom_range(1, 2);
      for (int k = 0; k < nbytes; k++) begin
        b    = 8'($urandom_range(0, 255));
        perr = ($urandom_range(0, 3) == 0);
        p    = odd_par_bit(b) ^ perr;
        send_bits(b, 8, 1'b0);
        send_bit(p, 1'b0);
        exp_q.push_back(ev(1, 0, 0, perr, 4'd8, b));
      end
      send_eof(1'b0);
      exp_q.push_back(ev(0, 1, 0, perr, 4'd8, b));
    end
    idle(4);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++;
        $display("FAIL back_to_back: got no event, expected %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          miscompares++;
          $display("FAIL back_to_back: got event %h, expected %h", o, e);
        end
      end
    end
    vectors++;
    if (obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL back_to_back: got %0d extra events, expected 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  // Sequence and final report
  initial begin
    test_reset();
    test_short_frame();
    test_parity();
    test_collision();
    test_glitch();
    test_rst_mid();
    test_majority();
    test_disable();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
